fir_tap_chain: RTL and testbench
================================

// Module: fir_tap_chain
// PURPOSE
//  Pipelined transposed-form FIR filter for the non-LI shell. Consumes a
//  data/valid sample stream and produces a filtered data/valid stream.
//  Sits directly upstream of the shell output pipeline_reg.
//  Coefficients are runtime-loadable through a simple write port.
// PARAMETERS
//  DATA_WIDTH  16  signed input/output sample width
//  COEF_WIDTH  16  signed coefficient width
//  NUM_TAPS    8   number of taps (>=2)
//  SHIFT       14  result right-shift (Q format of coefs); 0 <= SHIFT <= COEF_WIDTH-2
// PORTS
//  clock        in   1                      rising-edge clock
//  reset        in   1                      synchronous, active-high
//  i_data       in   DATA_WIDTH (signed)    input sample
//  i_valid      in   1                      i_data valid this cycle; no backpressure
//  i_coef_we    in   1                      coefficient write strobe
//  i_coef_addr  in   $clog2(NUM_TAPS)       tap index, 0 = newest sample
//  i_coef_data  in   COEF_WIDTH (signed)    coefficient value
//  o_data       out  DATA_WIDTH (signed)    filtered sample
//  o_valid      out  1                      o_data valid this cycle
//  o_sat        out  1                      o_data was saturated (qualified by o_valid)
// BEHAVIOUR
//  Reset: o_data=0, o_valid=0, o_sat=0. All pipeline and accumulator regs = 0.
//   coef[0]=2**SHIFT, all others 0, giving a unity-gain pure delay.
//   Reset has priority over a simultaneous coefficient write or sample.
//  Pipeline, 4 stages, fixed latency 4: i_valid at cycle t -> o_valid at t+4.
//   S1: register i_data, i_valid.
//   S2: p[k] = x*coef[k] for all k, full precision; register; valid follows.
//   S3: ACC_W = DATA_WIDTH+COEF_WIDTH+$clog2(NUM_TAPS) signed accumulators.
//       On S2 valid only: s[NUM_TAPS-1] <= p[NUM_TAPS-1];
//       s[k] <= p[k] + s[k+1] for 1<=k<NUM_TAPS-1; y <= p[0] + s[1].
//       With S2 invalid, s[] and y hold (filter state advances per sample,
//       not per cycle).
//   S4: if SHIFT>0, r = (y + 2**(SHIFT-1)) >>> SHIFT (round half up), else r = y.
//       Saturate r to [-2**(DATA_WIDTH-1), 2**(DATA_WIDTH-1)-1].
//       o_sat=1 when clamped. Registered into o_data, o_sat.
//  o_valid is the S3 valid delayed one cycle. When o_valid=0, o_data and o_sat
//   hold their last values.
//  Gaps: any i_valid pattern, including back-to-back, is supported at full rate.
//   Output = exact FIR of the valid-sample sequence, independent of gap spacing.
//  Coefficient write: while i_coef_we=1 at cycle t, coef[i_coef_addr] is updated
//   at t+1. The new value is used by any S2 multiply from t+1 onward. Samples
//   already past S2 are unaffected.
//   Address >= NUM_TAPS: write ignored.
//   Writes and samples may occur in the same cycle.
//  Reset mid-stream: all in-flight samples are discarded, o_valid=0 on the next
//   cycle, and coefficients revert to the reset set.
//  Arithmetic: all signed two's complement. No internal overflow is possible
//   at ACC_W.
// TESTING
//  1 Reset, then impulse 100 followed by zeros, all valid -> o_data 100 at t+4, then 0s.
//  2 SHIFT=0, load coef {1,2,3,4,0..}; impulse 1 -> outputs 1,2,3,4,0 on consecutive valids.
//  3 Same coefs, i_valid pattern 1,0,0,1,0,1 with samples 1,0,0 -> output values
//    identical to test 2, and o_valid mirrors the input pattern delayed by 4.
//  4 SHIFT=0, coef[0]=2, input 32767 -> o_data 32767, o_sat=1; input -32768 -> -32768, o_sat=1.
//  5 Default SHIFT=14, coef[0]=8192 (0.5), input 3 -> o_data 2 (1.5 rounded up), o_sat=0.
//  6 Reset asserted with 3 samples in flight -> no o_valid for those samples;
//    coef[addr=NUM_TAPS] write ignored; after reset, pass-through restored.

Source files
------------

// File: rtl/fir_tap_chain.sv
// Transposed-form FIR: sample register, tap multipliers, accumulator chain,
// then round/saturate. The tap coefficients can be rewritten while running.
module fir_tap_chain #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int NUM_TAPS   = 8,
  parameter int SHIFT      = 14
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic signed [DATA_WIDTH-1:0]  i_data,
  input  logic                          i_valid,
  input  logic                          i_coef_we,
  input  logic [$clog2(NUM_TAPS)-1:0]   i_coef_addr,
  input  logic signed [COEF_WIDTH-1:0]  i_coef_data,
  output logic signed [DATA_WIDTH-1:0]  o_data,
  output logic                          o_valid,
  output logic                          o_sat
);

  localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
  localparam int ACC_W  = PROD_W + $clog2(NUM_TAPS);
  localparam int EXT_W  = ACC_W + 1;
  localparam int unsigned RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [COEF_WIDTH-1:0] COEF_ONE = COEF_WIDTH'(2 ** SHIFT);
  localparam logic signed [EXT_W-1:0] RND_HALF =
    (SHIFT > 0) ? (EXT_W'(1) << RND_SH) : '0;
  localparam logic signed [EXT_W-1:0] OUT_MAX =
    EXT_W'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [EXT_W-1:0] OUT_MIN = ~OUT_MAX;

  logic signed [COEF_WIDTH-1:0] coef [NUM_TAPS];

  logic signed [DATA_WIDTH-1:0] s1_data;
  logic                         s1_valid;

  logic signed [PROD_W-1:0]     prod [NUM_TAPS];
  logic                         s2_valid;

  logic signed [ACC_W-1:0]      s [1:NUM_TAPS-1];
  logic signed [ACC_W-1:0]      y;
  logic                         s3_valid;

  logic signed [EXT_W-1:0]      rnd_sum;
  logic signed [EXT_W-1:0]      scaled;
  logic signed [DATA_WIDTH-1:0] sat_data;
  logic                         sat_flag;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
        coef[k] <= (k == 0) ? COEF_ONE : '0;
      end
    end else if (i_coef_we && (int'(i_coef_addr) < NUM_TAPS)) begin
      coef[i_coef_addr] <= i_coef_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_data  <= i_data;
      s1_valid <= i_valid;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
        prod[k] <= '0;
      end
      s2_valid <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
        prod[k] <= PROD_W'(s1_data) * PROD_W'(coef[k]);
      end
      s2_valid <= s1_valid;
    end
  end

  // Chain advances only on valid samples, so output is independent of gaps.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned k = 1; k < NUM_TAPS; k++) begin
        s[k] <= '0;
      end
      y        <= '0;
      s3_valid <= 1'b0;
    end else begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s[NUM_TAPS-1] <= ACC_W'(prod[NUM_TAPS-1]);
        for (int unsigned k = 1; k < NUM_TAPS - 1; k++) begin
          s[k] <= ACC_W'(prod[k]) + s[k+1];
        end
        y <= ACC_W'(prod[0]) + s[1];
      end
    end
  end

  // One guard bit above ACC_W keeps the rounding add from wrapping.
  always_comb begin
    rnd_sum  = {y[ACC_W-1], y} + RND_HALF;
    scaled   = rnd_sum >>> SHIFT;
    sat_data = scaled[DATA_WIDTH-1:0];
    sat_flag = 1'b0;
    if (scaled > OUT_MAX) begin
      sat_data = OUT_MAX[DATA_WIDTH-1:0];
      sat_flag = 1'b1;
    end else if (scaled < OUT_MIN) begin
      sat_data = OUT_MIN[DATA_WIDTH-1:0];
      sat_flag = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      o_data  <= '0;
      o_sat   <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= s3_valid;
      if (s3_valid) begin
        o_data <= sat_data;
        o_sat  <= sat_flag;
      end
    end
  end

endmodule

// File: tb/tb_fir_tap_chain.sv
module tb_fir_tap_chain;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] i_data = '0;
  logic               i_valid = 1'b0;
  logic               i_coef_we = 1'b0;
  logic [2:0]         i_coef_addr = '0;
  logic signed [15:0] i_coef_data = '0;

  logic signed [15:0] q14_data;
  logic               q14_valid;
  logic               q14_sat;
  logic signed [15:0] q0_data;
  logic               q0_valid;
  logic               q0_sat;

  int n_assert = 0;
  int n_fail   = 0;

  longint      ph [2][8][8];
  int          coefm [2][8];
  bit          vq [4];
  logic [15:0] last_d [2];
  logic        last_s [2];
  logic [16:0] exp_q0 [$];
  logic [16:0] exp_q1 [$];

  always #5 clock = ~clock;

  fir_tap_chain #(
    .DATA_WIDTH(16), .COEF_WIDTH(16), .NUM_TAPS(8), .SHIFT(14)
  ) dut_q14 (
    .clock(clock), .reset(reset), .i_data(i_data), .i_valid(i_valid),
    .i_coef_we(i_coef_we), .i_coef_addr(i_coef_addr), .i_coef_data(i_coef_data),
    .o_data(q14_data), .o_valid(q14_valid), .o_sat(q14_sat)
  );

  fir_tap_chain #(
    .DATA_WIDTH(16), .COEF_WIDTH(16), .NUM_TAPS(6), .SHIFT(0)
  ) dut_q0 (
    .clock(clock), .reset(reset), .i_data(i_data), .i_valid(i_valid),
    .i_coef_we(i_coef_we), .i_coef_addr(i_coef_addr), .i_coef_data(i_coef_data),
    .o_data(q0_data), .o_valid(q0_valid), .o_sat(q0_sat)
  );

  function automatic int nt(input int i);
    return (i == 0) ? 8 : 6;
  endfunction

  function automatic int sh(input int i);
    return (i == 0) ? 14 : 0;
  endfunction

  function automatic string nm(input int i);
    return (i == 0) ? "q14" : "q0";
  endfunction

  function automatic logic [16:0] expected(input int i);
    longint y = 0;
    for (int k = 0; k < nt(i); k++) y += ph[i][k][k];
    if (sh(i) > 0) y = (y + (longint'(1) <<< (sh(i) - 1))) >>> sh(i);
    if (y > 32767)  return {1'b1, 16'h7fff};
    if (y < -32768) return {1'b1, 16'h8000};
    return {1'b0, 16'(y)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        for (int a = 0; a < 8; a++)
          for (int k = 0; k < 8; k++) ph[i][a][k] = 0;
        for (int k = 0; k < 8; k++) coefm[i][k] = 0;
        coefm[i][0] = 1 << sh(i);
        last_d[i] = '0;
        last_s[i] = 1'b0;
      end
      for (int a = 0; a < 4; a++) vq[a] = 1'b0;
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (i_coef_we && (int'(i_coef_addr) < nt(i)))
          coefm[i][i_coef_addr] = int'(i_coef_data);
        if (i_valid) begin
          for (int a = nt(i) - 1; a > 0; a--)
            for (int k = 0; k < 8; k++) ph[i][a][k] = ph[i][a-1][k];
          for (int k = 0; k < nt(i); k++)
            ph[i][0][k] = longint'(i_data) * longint'(coefm[i][k]);
          if (i == 0) exp_q0.push_back(expected(0));
          else        exp_q1.push_back(expected(1));
        end
      end
      for (int a = 3; a > 0; a--) vq[a] = vq[a-1];
      vq[0] = i_valid;
    end
  endtask

  task automatic check_inst(input int i, input logic [15:0] od, input logic ov, input logic os);
    logic [16:0] e;
    check($sformatf("%s_valid", nm(i)), {31'h0, ov}, {31'h0, vq[3]});
    if (vq[3]) begin
      if (i == 0) e = (exp_q0.size() > 0) ? exp_q0.pop_front() : 'x;
      else        e = (exp_q1.size() > 0) ? exp_q1.pop_front() : 'x;
      last_d[i] = e[15:0];
      last_s[i] = e[16];
    end
    check($sformatf("%s_data", nm(i)), {16'h0, od}, {16'h0, last_d[i]});
    check($sformatf("%s_sat", nm(i)), {31'h0, os}, {31'h0, last_s[i]});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    model_edge();
    check_inst(0, q14_data, q14_valid, q14_sat);
    check_inst(1, q0_data, q0_valid, q0_sat);
  endtask

  task automatic cyc(input bit v, input int d);
    i_valid = v;
    i_data  = 16'(d);
    tick();
    i_valid = 1'b0;
  endtask

  task automatic wr(input int a, input int c);
    i_coef_we   = 1'b1;
    i_coef_addr = 3'(a);
    i_coef_data = 16'(c);
    tick();
    i_coef_we   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load_ramp();
    wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    // reset state
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // impulse through the unity-gain reset coefficients
    cyc(1, 100);
    repeat (7) cyc(1, 0);
    idle(5);

    // ramp coefficients, impulse on consecutive valids
    do_reset();
    load_ramp();
    cyc(1, 1);
    repeat (5) cyc(1, 0);
    idle(5);

    // same coefficients with gaps; invalid slots carry junk data
    do_reset();
    load_ramp();
    cyc(1, 1); cyc(0, 999); cyc(0, -999); cyc(1, 0); cyc(0, 12345); cyc(1, 0);
    cyc(1, 0); cyc(0, 7); cyc(1, 0);
    idle(5);

    // saturation at both rails and just inside
    do_reset();
    wr(0, 2);
    cyc(1, 32767); cyc(1, -32768); cyc(1, 16383); cyc(1, 16384);
    cyc(1, -16384); cyc(1, -16385); cyc(1, 0);
    idle(5);

    // half-coefficient rounding, write and sample in the same cycle
    do_reset();
    wr(0, 8192);
    cyc(1, 3); cyc(1, -3); cyc(1, 1); cyc(1, -1);
    i_coef_we = 1'b1; i_coef_addr = 3'd0; i_coef_data = 16'sd3;
    cyc(1, 7);
    i_coef_we = 1'b0;
    cyc(1, 0);
    idle(5);

    // reset with samples in flight, out-of-range write on the 6-tap instance
    do_reset();
    wr(1, 300);
    cyc(1, 10); cyc(1, 20); cyc(1, 30);
    reset = 1'b1; i_valid = 1'b1; i_data = 16'sd40;
    i_coef_we = 1'b1; i_coef_addr = 3'd0; i_coef_data = 16'sd99;
    tick();
    reset = 1'b0; i_valid = 1'b0; i_coef_we = 1'b0;
    idle(4);
    wr(6, 1234);
    cyc(1, 1000);
    repeat (7) cyc(1, 0);
    idle(5);

    // randomised mix of gaps, samples and coefficient writes
    for (int n = 0; n < 80; n++) begin
      i_valid     = ($urandom_range(0, 3) != 0);
      i_data      = 16'($urandom_range(0, 65535));
      i_coef_we   = ($urandom_range(0, 7) == 0);
      i_coef_addr = 3'($urandom_range(0, 7));
      i_coef_data = 16'(int'($urandom_range(0, 2047)) - 1024);
      tick();
    end
    i_valid = 1'b0;
    i_coef_we = 1'b0;
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
